// File: rtl/drive_pkg.sv
// drive_pkg: command op codes, sequencer states, bridge direction encoding and op decode
package drive_pkg;

    localparam logic [2:0] OP_STOP  = 3'd0;
    localparam logic [2:0] OP_FWD   = 3'd1;
    localparam logic [2:0] OP_BKWD  = 3'd2;
    localparam logic [2:0] OP_LEFT  = 3'd3;
    localparam logic [2:0] OP_RIGHT = 3'd4;

    typedef enum logic [1:0] {IDLE, RUN, DEAD, FAULT} state_t;

    // Bit 1 drives IN1/IN3, bit 0 drives IN2/IN4
    typedef enum logic [1:0] {COAST = 2'b00, REV = 2'b01, FWD = 2'b10} dir_t;

    typedef struct packed {
        dir_t a;
        dir_t b;
    } dirs_t;

    // Reserved op codes 5-7 behave as STOP
    function automatic logic [2:0] norm_op(input logic [2:0] op);
        return (op > OP_RIGHT) ? OP_STOP : op;
    endfunction

    function automatic dirs_t op_dir(input logic [2:0] op);
        dirs_t d;
        d.a = (op == OP_FWD || op == OP_RIGHT) ? FWD : (op == OP_BKWD || op == OP_LEFT) ? REV : COAST;
        d.b = (op == OP_FWD || op == OP_LEFT) ? FWD : (op == OP_BKWD || op == OP_RIGHT) ? REV : COAST;
        return d;
    endfunction

endpackage

// File: rtl/drive_pwm.sv
// drive_pwm: free-running PWM carrier with one duty comparator per track
module drive_pwm #(
    parameter int DUTY_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DUTY_W-1:0] duty_a,
    input  logic [DUTY_W-1:0] duty_b,
    output logic              EnableA,
    output logic              EnableB
);

    logic [DUTY_W-1:0] pwm_cnt;

    // carrier counter, wraps naturally after 2^DUTY_W-1
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            pwm_cnt <= '0;
        else
            pwm_cnt <= pwm_cnt + 1'b1;
    end

    assign EnableA = pwm_cnt < duty_a;
    assign EnableB = pwm_cnt < duty_b;

endmodule

// File: rtl/drive_sequencer.sv
// drive_sequencer: command-level H-bridge controller with dead-time and overcurrent retry.
// Define DRIVE_RAMP_EN to slew duty toward the target one LSB every RAMP_DIV cycles.
module drive_sequencer
    import drive_pkg::*;
#(
    parameter int DUTY_W       = 8,
    parameter int DEAD_CYCLES  = 1000,
    parameter int RETRY_CYCLES = 100000,
    parameter int RAMP_DIV     = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [2:0]        cmd_op,
    input  logic [DUTY_W-1:0] cmd_duty,
    input  logic              DisableA,
    input  logic              DisableB,
    output logic              IN1,
    output logic              IN2,
    output logic              IN3,
    output logic              IN4,
    output logic              EnableA,
    output logic              EnableB,
    output logic              fault_a,
    output logic              fault_b,
    output logic              busy
);

    localparam int MAXC = (DEAD_CYCLES > RETRY_CYCLES) ? DEAD_CYCLES : RETRY_CYCLES;
    localparam int CW   = $clog2(MAXC) + 1;

    state_t            state, state_n;
    logic [CW-1:0]     cnt, cnt_n;
    logic [2:0]        op, op_n, pend, pend_n, cmd;
    logic [DUTY_W-1:0] target, target_n, duty_cur, duty_n;
    logic              fa_n, fb_n, busy_n, oc_a, oc_b, accept;
    logic [3:0]        in_q, in_n;
    logic [1:0]        sync_a, sync_b;
    dirs_t             dirs;

    // two-flop synchronizers for the asynchronous overcurrent flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_a <= '0;
            sync_b <= '0;
        end else begin
            sync_a <= {sync_a[0], DisableA};
            sync_b <= {sync_b[0], DisableB};
        end
    end

    assign oc_a      = sync_a[1];
    assign oc_b      = sync_b[1];
    assign cmd       = norm_op(cmd_op);
    assign cmd_ready = (state == IDLE || state == RUN) && !oc_a && !oc_b && !rst;
    assign accept    = cmd_valid && cmd_ready;

    // state register plus the registered bridge, busy and fault outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            op       <= OP_STOP;
            pend     <= OP_STOP;
            target   <= '0;
            duty_cur <= '0;
            fault_a  <= 1'b0;
            fault_b  <= 1'b0;
            in_q     <= '0;
            busy     <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            op       <= op_n;
            pend     <= pend_n;
            target   <= target_n;
            duty_cur <= duty_n;
            fault_a  <= fa_n;
            fault_b  <= fb_n;
            in_q     <= in_n;
            busy     <= busy_n;
        end
    end

    // next state: overcurrent outranks both command acceptance and dead-time expiry
    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        op_n     = op;
        pend_n   = pend;
        target_n = target;
        fa_n     = fault_a;
        fb_n     = fault_b;
        if (oc_a || oc_b) begin
            target_n = '0;
            op_n     = OP_STOP;
            if (state != FAULT) begin
                state_n = FAULT;
                cnt_n   = CW'(RETRY_CYCLES - 1);
                fa_n    = oc_a;
                fb_n    = oc_b;
            end else begin
                fa_n = fault_a | oc_a;
                fb_n = fault_b | oc_b;
                if (cnt != '0)
                    cnt_n = cnt - 1'b1;
            end
        end else begin
            case (state)
                IDLE, RUN: begin
                    if (accept) begin
                        fa_n     = 1'b0;
                        fb_n     = 1'b0;
                        target_n = (cmd == OP_STOP) ? '0 : cmd_duty;
                        if (state == IDLE) begin
                            state_n = (cmd == OP_STOP) ? IDLE : RUN;
                            op_n    = cmd;
                        end else if (cmd != op) begin
                            state_n = DEAD;
                            pend_n  = cmd;
                            cnt_n   = CW'(DEAD_CYCLES - 1);
                        end
                    end
                end
                DEAD: begin
                    if (cnt == '0) begin
                        state_n = (pend == OP_STOP) ? IDLE : RUN;
                        op_n    = pend;
                    end else begin
                        cnt_n = cnt - 1'b1;
                    end
                end
                default: begin
                    if (cnt == '0)
                        state_n = IDLE;
                    else
                        cnt_n = cnt - 1'b1;
                end
            endcase
        end
    end

    // outputs decoded from the next state so they register alongside it
    always_comb begin
        dirs   = op_dir(op_n);
        in_n   = (state_n == RUN) ? {dirs.a, dirs.b} : 4'b0000;
        busy_n = (state_n == DEAD) || (state_n == FAULT);
    end

`ifdef DRIVE_RAMP_EN
    localparam int RW = $clog2(RAMP_DIV) + 1;

    logic [RW-1:0] ramp_cnt, ramp_n;
    logic          tick;

    assign tick = ramp_cnt == RW'(RAMP_DIV - 1);

    // slew duty one LSB per RAMP_DIV cycles while running, restarting from 0 on RUN entry
    always_comb begin
        ramp_n = (state == RUN && state_n == RUN && !tick) ? ramp_cnt + 1'b1 : '0;
        duty_n = duty_cur;
        if (state != RUN || state_n != RUN)
            duty_n = '0;
        else if (tick && duty_cur < target_n)
            duty_n = duty_cur + 1'b1;
        else if (tick && duty_cur > target_n)
            duty_n = duty_cur - 1'b1;
    end

    // ramp step divider
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            ramp_cnt <= '0;
        else
            ramp_cnt <= ramp_n;
    end
`else
    assign duty_n = (state_n == RUN) ? target_n : '0;
`endif

    assign {IN1, IN2, IN3, IN4} = in_q;

    drive_pwm #(.DUTY_W(DUTY_W)) u_pwm (
        .clk     (clk),
        .rst     (rst),
        .duty_a  (duty_cur),
        .duty_b  (duty_cur),
        .EnableA (EnableA),
        .EnableB (EnableB)
    );

endmodule

// File: tb/tb_drive_sequencer.sv
// tb_drive_sequencer: directed table, corner sequences and random stimulus against a behavioural model
module tb_drive_sequencer;

    localparam int DW = 8, DEAD = 4, RETRY = 8, RDIV = 2;

    logic          clk = 1'b0, rst = 1'b1, cmd_valid = 1'b0, DisableA = 1'b0, DisableB = 1'b0;
    logic [2:0]    cmd_op = '0;
    logic [DW-1:0] cmd_duty = '0;
    logic          cmd_ready, IN1, IN2, IN3, IN4, EnableA, EnableB, fault_a, fault_b, busy;

    int n_vec = 0, n_bad = 0;

    // behavioural model: drive = op being driven (0 when idle), timers count remaining cycles
    int drive, pend, dead_left, retry_left, target, mduty, phase, cyc;
    bit in_fault, fa, fb, s1a, s1b, oca, ocb;
    logic [3:0] pat [5] = '{4'b0000, 4'b1010, 4'b0101, 4'b0110, 4'b1001};

    typedef struct {
        logic       valid;
        logic [2:0] op;
        logic [7:0] duty;
        logic [3:0] in;
        logic       ready;
        logic       busy;
    } vec_t;

    vec_t tbl [21];

    drive_sequencer #(.DUTY_W(DW), .DEAD_CYCLES(DEAD), .RETRY_CYCLES(RETRY), .RAMP_DIV(RDIV)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_duty(cmd_duty), .DisableA(DisableA), .DisableB(DisableB), .IN1(IN1), .IN2(IN2),
        .IN3(IN3), .IN4(IN4), .EnableA(EnableA), .EnableB(EnableB), .fault_a(fault_a),
        .fault_b(fault_b), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic bit running();
        return !in_fault && dead_left == 0 && drive != 0;
    endfunction

    task automatic model_reset();
        drive = 0; pend = 0; dead_left = 0; retry_left = 0; target = 0; mduty = 0; phase = 0; cyc = 0;
        in_fault = 0; fa = 0; fb = 0; s1a = 0; s1b = 0; oca = 0; ocb = 0;
    endtask

    // one clock: advance the model with the applied inputs and compare every output
    task automatic step();
        bit acc, run_pre, run_post, oc;
        int c;
        oc = oca || ocb;
        acc = !in_fault && dead_left == 0 && !oc && cmd_valid;
        c = (cmd_op > 4) ? 0 : int'(cmd_op);
        run_pre = running();
        @(posedge clk);
        #1;
        cyc++;
        if (oc && !in_fault) begin
            in_fault = 1; retry_left = RETRY; fa = oca; fb = ocb; drive = 0; dead_left = 0; target = 0;
        end else if (in_fault) begin
            fa |= oca; fb |= ocb;
            if (retry_left > 0) retry_left--;
            if (retry_left == 0 && !oc) in_fault = 0;
        end else if (dead_left > 0) begin
            dead_left--;
            if (dead_left == 0) drive = pend;
        end else if (acc) begin
            fa = 0; fb = 0;
            target = (c == 0) ? 0 : int'(cmd_duty);
            if (drive == 0) drive = c;
            else if (c != drive) begin dead_left = DEAD; pend = c; end
        end
        oca = s1a; s1a = DisableA;
        ocb = s1b; s1b = DisableB;
        run_post = running();
`ifdef DRIVE_RAMP_EN
        if (!run_pre || !run_post) begin
            mduty = 0; phase = 0;
        end else if (phase == RDIV - 1) begin
            phase = 0;
            if (mduty < target) mduty++;
            else if (mduty > target) mduty--;
        end else begin
            phase++;
        end
`else
        mduty = run_post ? target : 0;
        if (run_pre) phase = 0;
`endif
        chk("in", {IN1, IN2, IN3, IN4}, run_post ? 32'(pat[drive]) : 32'd0);
        chk("ready", cmd_ready, !in_fault && dead_left == 0 && !(oca || ocb));
        chk("busy", busy, in_fault || dead_left > 0);
        chk("fault_a", fault_a, fa);
        chk("fault_b", fault_b, fb);
        chk("enable_a", EnableA, (cyc % 256) < mduty);
        chk("enable_b", EnableB, (cyc % 256) < mduty);
    endtask

    task automatic send(input logic [2:0] op, input int duty);
        cmd_valid = 1; cmd_op = op; cmd_duty = DW'(duty);
        step();
        cmd_valid = 0;
    endtask

    task automatic do_reset();
        rst = 1;
        repeat (2) @(posedge clk);
        #1;
        rst = 0;
        model_reset();
        #1;
        chk("ready_after_reset", cmd_ready, 1);
        chk("in_after_reset", {IN1, IN2, IN3, IN4}, 0);
        chk("busy_after_reset", busy, 0);
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int k, cnt_a, cnt_b, da_left, db_left;

        tbl[0]  = '{1'b1, 3'd1, 8'd128, 4'b1010, 1'b1, 1'b0};
        tbl[1]  = '{1'b0, 3'd0, 8'd0,   4'b1010, 1'b1, 1'b0};
        tbl[2]  = '{1'b1, 3'd3, 8'd128, 4'b0000, 1'b0, 1'b1};
        tbl[3]  = '{1'b1, 3'd1, 8'd100, 4'b0000, 1'b0, 1'b1};
        tbl[4]  = '{1'b0, 3'd0, 8'd0,   4'b0000, 1'b0, 1'b1};
        tbl[5]  = '{1'b0, 3'd0, 8'd0,   4'b0000, 1'b0, 1'b1};
        tbl[6]  = '{1'b0, 3'd0, 8'd0,   4'b0110, 1'b1, 1'b0};
        tbl[7]  = '{1'b1, 3'd3, 8'd64,  4'b0110, 1'b1, 1'b0};
        tbl[8]  = '{1'b1, 3'd6, 8'd10,  4'b0000, 1'b0, 1'b1};
        tbl[9]  = '{1'b0, 3'd0, 8'd0,   4'b0000, 1'b0, 1'b1};
        tbl[10] = '{1'b0, 3'd0, 8'd0,   4'b0000, 1'b0, 1'b1};
        tbl[11] = '{1'b0, 3'd0, 8'd0,   4'b0000, 1'b0, 1'b1};
        tbl[12] = '{1'b0, 3'd0, 8'd0,   4'b0000, 1'b1, 1'b0};
        tbl[13] = '{1'b1, 3'd4, 8'd200, 4'b1001, 1'b1, 1'b0};
        tbl[14] = '{1'b1, 3'd7, 8'd0,   4'b0000, 1'b0, 1'b1};
        tbl[15] = '{1'b0, 3'd0, 8'd0,   4'b0000, 1'b0, 1'b1};
        tbl[16] = '{1'b0, 3'd0, 8'd0,   4'b0000, 1'b0, 1'b1};
        tbl[17] = '{1'b0, 3'd0, 8'd0,   4'b0000, 1'b0, 1'b1};
        tbl[18] = '{1'b1, 3'd2, 8'd50,  4'b0000, 1'b1, 1'b0};
        tbl[19] = '{1'b1, 3'd2, 8'd50,  4'b0101, 1'b1, 1'b0};
        tbl[20] = '{1'b0, 3'd0, 8'd0,   4'b0101, 1'b1, 1'b0};

        do_reset();

        // asynchronous reset in the middle of RUN
        send(3'd1, 128);
        repeat (5) step();
        #2;
        rst = 1;
        #1;
        chk("async_rst_in", {IN1, IN2, IN3, IN4}, 0);
        chk("async_rst_en", {EnableA, EnableB}, 0);
        chk("async_rst_ready", cmd_ready, 0);
        do_reset();

        // directed table from IDLE
        foreach (tbl[i]) begin
            cmd_valid = tbl[i].valid; cmd_op = tbl[i].op; cmd_duty = tbl[i].duty;
            step();
            chk($sformatf("tbl%0d_in", i), {IN1, IN2, IN3, IN4}, tbl[i].in);
            chk($sformatf("tbl%0d_ready", i), cmd_ready, tbl[i].ready);
            chk($sformatf("tbl%0d_busy", i), busy, tbl[i].busy);
        end
        cmd_valid = 0;

        // PWM duty over a full period, then a same-op duty change with no dead-time
        send(3'd2, 128);
        repeat (300) step();
        cnt_a = 0; cnt_b = 0;
        repeat (256) begin step(); cnt_a += int'(EnableA); cnt_b += int'(EnableB); end
        chk("pwm128_a", cnt_a, 128);
        chk("pwm128_b", cnt_b, 128);
        send(3'd2, 64);
        chk("resend_no_dead", {IN1, IN2, IN3, IN4, busy}, 5'b01010);
        repeat (300) step();
        cnt_a = 0;
        repeat (256) begin step(); cnt_a += int'(EnableA); end
        chk("pwm64_a", cnt_a, 64);

        // one-cycle DisableA pulse while a command is held
        cmd_valid = 1; cmd_op = 3'd2; cmd_duty = 8'd64; DisableA = 1;
        step();
        DisableA = 0;
        k = 1;
        while ({IN1, IN2, IN3, IN4} != 0 && k < 10) begin step(); k++; end
        chk("oc_latency", k, 3);
        chk("oc_enable_off", {EnableA, EnableB}, 0);
        chk("oc_fault_bits", {fault_a, fault_b}, 2'b10);
        step();
        chk("oc_cmd_blocked", {IN1, IN2, IN3, IN4, cmd_ready}, 0);
        cmd_valid = 0;
        k = 1;
        while (busy && k < 50) begin step(); k++; end
        chk("retry_len", k, 8);
        chk("retry_idle", {IN1, IN2, IN3, IN4, cmd_ready}, 5'b00001);

        // DisableA held 20 cycles: recovery only once the synchronized flag drops
        send(3'd1, 100);
        DisableA = 1;
        k = 0;
        repeat (20) begin step(); k++; end
        DisableA = 0;
        while (busy && k < 100) begin step(); k++; end
        chk("hold_release", k, 23);

        // DisableB rising exactly as dead-time expires
        send(3'd1, 100);
        send(3'd2, 100);
        step();
        DisableB = 1;
        step();
        DisableB = 0;
        step();
        chk("sim_dead", {IN1, IN2, IN3, IN4, busy}, 5'b00001);
        step();
        chk("sim_fault", {IN1, IN2, IN3, IN4, busy, fault_a, fault_b}, 7'b0000101);
        k = 0;
        while (busy && k < 50) begin step(); k++; end
        chk("sim_pend_dropped", {IN1, IN2, IN3, IN4, cmd_ready}, 5'b00001);

        // randomized traffic with sporadic overcurrent bursts
        da_left = 0; db_left = 0;
        repeat (3000) begin
            cmd_valid = 1'($urandom_range(0, 1));
            cmd_op = 3'($urandom_range(0, 7));
            cmd_duty = DW'($urandom);
            if (da_left > 0) da_left--;
            else if ($urandom_range(0, 199) == 0) da_left = $urandom_range(1, 30);
            if (db_left > 0) db_left--;
            else if ($urandom_range(0, 199) == 0) db_left = $urandom_range(1, 30);
            DisableA = da_left > 0;
            DisableB = db_left > 0;
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
